// File: rtl/lenet_fetch_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : lenet_fetch_scheduler_if
// Brief    : Frame buffer port sharing and LeNet pixel stream bundle.
// Revision : 1.0
// ============================================================================
interface lenet_fetch_scheduler_if;
    logic        vga_active;
    logic [18:0] vga_addr;
    logic [18:0] mem_addr;
    logic [3:0]  mem_pixel;
    logic        start;
    logic        busy;
    logic        done;
    logic        px_valid;
    logic        px_ready;
    logic [3:0]  px_data;
    logic [9:0]  px_index;

    modport master (
        output vga_active, vga_addr, mem_pixel, start, px_ready,
        input  mem_addr, busy, done, px_valid, px_data, px_index
    );

    modport slave (
        input  vga_active, vga_addr, mem_pixel, start, px_ready,
        output mem_addr, busy, done, px_valid, px_data, px_index
    );
endinterface
`default_nettype wire

// File: rtl/lenet_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lenet_fetch_scheduler
// Brief    : Fetches a sampled grid for LeNet from the frame buffer in cycles
//            VGA scanout leaves free; VGA always owns the read port first.
// Revision : 1.0
// ============================================================================
module lenet_fetch_scheduler #(
    parameter int WIDTHLENGTH  = 8,
    parameter int HEIGHTLENGTH = 8,
    parameter int LENET_SIZE   = 28,
    parameter int HREZ         = 640,
    parameter int X0           = 212,
    parameter int Y0           = 132
) (
    input wire                     clk25,
    input wire                     rst,
    lenet_fetch_scheduler_if.slave bus
);

    localparam logic [18:0] c_row0     = 19'(Y0 * HREZ);
    localparam logic [18:0] c_row_step = 19'(HEIGHTLENGTH * HREZ);
    localparam logic [18:0] c_col_step = 19'(WIDTHLENGTH);
    localparam logic [18:0] c_x0       = 19'(X0);
    localparam logic [4:0]  c_last     = 5'(LENET_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_busy;
    logic        r_done;
    logic        r_px_valid;
    logic        r_inflight;
    logic [3:0]  r_px_data;
    logic [9:0]  r_px_index;
    logic [9:0]  r_issue_idx;
    logic [9:0]  r_inflight_idx;
    logic [4:0]  r_row;
    logic [4:0]  r_col;
    logic [18:0] r_row_base;
    logic [18:0] r_col_off;

    logic [18:0] w_fetch_addr;
    logic        w_issue;
    logic        w_handshake;
    logic        w_last;
    logic        w_launch;

    always_comb begin
        w_fetch_addr = r_row_base + c_x0 + r_col_off;
        w_handshake  = r_px_valid && bus.px_ready;
        w_last       = (r_row == c_last) && (r_col == c_last);
        // A read may only go out when its result has somewhere to land.
        w_issue      = (r_state == S_RUN) && !bus.vga_active && !r_inflight &&
                       (!r_px_valid || bus.px_ready);
        w_launch     = (r_state == S_IDLE) && bus.start && !r_done;

        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch)           w_state_next = S_RUN;
            S_RUN:   if (w_issue && w_last)  w_state_next = S_DRAIN;
            S_DRAIN: if (w_handshake)        w_state_next = S_IDLE;
            default:                         w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_px_valid     <= 1'b0;
            r_inflight     <= 1'b0;
            r_px_data      <= 4'd0;
            r_px_index     <= 10'd0;
            r_issue_idx    <= 10'd0;
            r_inflight_idx <= 10'd0;
            r_row          <= 5'd0;
            r_col          <= 5'd0;
            r_row_base     <= 19'd0;
            r_col_off      <= 19'd0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= (r_state == S_DRAIN) && w_handshake;
            r_inflight <= w_issue;

            if (w_launch) begin
                r_busy      <= 1'b1;
                r_row       <= 5'd0;
                r_col       <= 5'd0;
                r_row_base  <= c_row0;
                r_col_off   <= 19'd0;
                r_issue_idx <= 10'd0;
            end else if ((r_state == S_DRAIN) && w_handshake) begin
                r_busy <= 1'b0;
            end

            if (w_issue) begin
                r_inflight_idx <= r_issue_idx;
                r_issue_idx    <= r_issue_idx + 10'd1;
                if (r_col == c_last) begin
                    r_col      <= 5'd0;
                    r_col_off  <= 19'd0;
                    r_row      <= r_row + 5'd1;
                    r_row_base <= r_row_base + c_row_step;
                end else begin
                    r_col     <= r_col + 5'd1;
                    r_col_off <= r_col_off + c_col_step;
                end
            end

            // Read data is captured regardless of vga_active: the address was issued last cycle.
            if (r_inflight) begin
                r_px_data  <= bus.mem_pixel;
                r_px_index <= r_inflight_idx;
                r_px_valid <= 1'b1;
            end else if (w_handshake) begin
                r_px_valid <= 1'b0;
            end
        end
    end

    assign bus.mem_addr = bus.vga_active ? bus.vga_addr : w_fetch_addr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.px_valid = r_px_valid;
    assign bus.px_data  = r_px_data;
    assign bus.px_index = r_px_index;

endmodule
`default_nettype wire

// File: tb/tb_lenet_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lenet_fetch_scheduler
// Brief    : Directed self-checking bench for lenet_fetch_scheduler.
// Revision : 1.0
// ============================================================================
module tb_lenet_fetch_scheduler;

    logic       clk25;
    logic       rst;
    logic [3:0] salt;
    int         total;
    int         bad;
    int         sb_idx;
    int         done_cnt;
    logic       got;

    lenet_fetch_scheduler_if u_if ();

    lenet_fetch_scheduler dut (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (u_if.slave)
    );

    initial clk25 = 1'b0;
    always #5 clk25 = ~clk25;

    function automatic logic [18:0] addr_of(input int i);
        return 19'((132 + (i / 28) * 8) * 640 + 212 + (i % 28) * 8);
    endfunction

    function automatic logic [3:0] pix(input logic [18:0] a);
        return a[3:0] ^ a[7:4] ^ salt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame buffer: data for an address appears the following cycle.
    always @(posedge clk25) u_if.mem_pixel <= pix(u_if.mem_addr);

    // Stream scoreboard and port mux monitor.
    always @(negedge clk25) begin
        if (rst) begin
            sb_idx = 0;
        end else begin
            if (u_if.vga_active)
                check("mux_vga", 32'(u_if.mem_addr), 32'(u_if.vga_addr));
            if (u_if.px_valid && u_if.px_ready) begin
                check("px_index", 32'(u_if.px_index), 32'(sb_idx));
                check("px_data", 32'(u_if.px_data), 32'(pix(addr_of(sb_idx))));
                sb_idx++;
            end
            if (u_if.done) begin
                done_cnt++;
                check("done_count_px", 32'(sb_idx), 32'd784);
                check("busy_at_done", 32'(u_if.busy), 32'd0);
                sb_idx = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic pulse_start();
        u_if.start = 1'b1;
        step();
        u_if.start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        got = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk25);
            if (u_if.done) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 32'(got), 32'd1);
        step();
    endtask

    initial begin
        total = 0; bad = 0; sb_idx = 0; done_cnt = 0; salt = 4'd0; got = 1'b0;
        rst = 1'b1;
        u_if.vga_active = 1'b0;
        u_if.vga_addr   = 19'd0;
        u_if.start      = 1'b0;
        u_if.px_ready   = 1'b1;
        repeat (3) step();
        @(negedge clk25);
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_done", 32'(u_if.done), 32'd0);
        check("rst_valid", 32'(u_if.px_valid), 32'd0);
        check("rst_data", 32'(u_if.px_data), 32'd0);
        check("rst_index", 32'(u_if.px_index), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Free-running fetch: one read every two cycles.
        pulse_start();
        check("busy_after_start", 32'(u_if.busy), 32'd1);
        for (int k = 0; k < 784; k++) begin
            @(negedge clk25);
            check("issue_addr", 32'(u_if.mem_addr), 32'(addr_of(k)));
            step();
            step();
        end
        wait_done(10, "done_free");
        check("done_pulse_len", 32'(u_if.done), 32'd0);
        check("busy_after_done", 32'(u_if.busy), 32'd0);
        check("done_cnt_a", 32'(done_cnt), 32'd1);

        // VGA owns the port for 1000 cycles right after start.
        u_if.vga_active = 1'b1;
        pulse_start();
        for (int c = 0; c < 1000; c++) begin
            u_if.vga_addr = 19'($urandom_range(0, 307199));
            @(negedge clk25);
            check("vga_stall_valid", 32'(u_if.px_valid), 32'd0);
            step();
        end
        u_if.vga_active = 1'b0;
        wait_done(4000, "done_vga_stall");
        check("done_cnt_b", 32'(done_cnt), 32'd2);

        // Downstream backpressure on the first pixel.
        salt = 4'd3;
        u_if.px_ready = 1'b0;
        pulse_start();
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk25);
            got = u_if.px_valid;
            step();
        end
        check("bp_first_valid", 32'(got), 32'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk25);
            check("bp_valid", 32'(u_if.px_valid), 32'd1);
            check("bp_data", 32'(u_if.px_data), 32'hA);
            check("bp_index", 32'(u_if.px_index), 32'd0);
            step();
        end
        u_if.px_ready = 1'b1;
        wait_done(4000, "done_backpressure");
        check("done_cnt_c", 32'(done_cnt), 32'd3);
        salt = 4'd0;

        // Repeated start mid-fetch must not disturb the sequence.
        pulse_start();
        repeat (100) step();
        pulse_start();
        wait_done(4000, "done_restart_ignored");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk25);
            check("no_extra_done", 32'(u_if.done), 32'd0);
            step();
        end
        check("done_cnt_d", 32'(done_cnt), 32'd4);

        // Reset while pixel 400 is on the output.
        pulse_start();
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk25);
            got = u_if.px_valid && (u_if.px_index == 10'd400);
            step();
        end
        check("reach_400", 32'(got), 32'd1);
        rst = 1'b1;
        step();
        check("abort_busy", 32'(u_if.busy), 32'd0);
        check("abort_valid", 32'(u_if.px_valid), 32'd0);
        check("abort_done", 32'(u_if.done), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk25);
            check("abort_no_done", 32'(u_if.done), 32'd0);
            step();
        end
        check("done_cnt_e", 32'(done_cnt), 32'd4);
        pulse_start();
        @(negedge clk25);
        check("restart_addr", 32'(u_if.mem_addr), 32'd84692);
        wait_done(4000, "done_after_abort");
        check("done_cnt_f", 32'(done_cnt), 32'd5);

        // Random port contention and backpressure.
        pulse_start();
        got = 1'b0;
        for (int c = 0; c < 20000 && !got; c++) begin
            u_if.vga_active = 1'($urandom_range(0, 1));
            u_if.px_ready   = 1'($urandom_range(0, 1));
            u_if.vga_addr   = 19'($urandom_range(0, 307199));
            @(negedge clk25);
            got = u_if.done;
            step();
        end
        check("done_random", 32'(got), 32'd1);
        check("done_cnt_g", 32'(done_cnt), 32'd6);
        u_if.vga_active = 1'b0;
        u_if.px_ready   = 1'b1;
        @(negedge clk25);
        check("idle_busy", 32'(u_if.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
